// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the regfile write port between WB (priority) and a queued MDU result bus; REGFILE_ARB_BYPASS_EN adds a same-cycle MDU bypass
module regfile_wr_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_wren,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic        i_mdu_valid,
  output logic        o_mdu_ready,
  input  logic [4:0]  i_mdu_addr,
  input  logic [31:0] i_mdu_data,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd,
  output logic [31:0] o_busy,
  output logic        o_stall_req,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  logic [4:0]  q_addr [FIFO_DEPTH];
  logic [31:0] q_data [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [3:0]  wait_cnt, wait_inc;
  logic        empty, full, accept, push, pop, byp;
  logic [4:0]  head_addr;
  logic [31:0] head_data, set_mask, clr_mask;
  assign empty       = wr_ptr == rd_ptr;
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_mdu_ready = !i_reset && !full;
  assign accept      = i_mdu_valid && o_mdu_ready;
`ifdef REGFILE_ARB_BYPASS_EN
  assign byp         = empty && !i_wb_wren && accept && i_mdu_addr != 5'd0;
`else
  assign byp         = 1'b0;
`endif
  assign push        = accept && i_mdu_addr != 5'd0 && !byp;
  assign pop         = !i_reset && !i_wb_wren && !empty;
  assign head_addr   = q_addr[rd_ptr[AW-1:0]];
  assign head_data   = q_data[rd_ptr[AW-1:0]];
  assign wait_inc    = wait_cnt + {3'd0, wait_cnt != 4'hf};
  // port select: wb first, then FIFO head, then (optionally) bypassed MDU result
  always_comb begin
    o_rd_wren = !i_reset && (i_wb_wren || !empty || byp);
    o_rd_addr = i_reset ? 5'd0 : i_wb_wren ? i_wb_addr : !empty ? head_addr : byp ? i_mdu_addr : 5'd0;
    o_rd_data = i_reset ? 32'd0 : i_wb_wren ? i_wb_data : !empty ? head_data : byp ? i_mdu_data : 32'd0;
    set_mask  = (i_issue_valid && i_issue_rd != 5'd0) ? 32'd1 << i_issue_rd : 32'd0;
    clr_mask  = (pop ? 32'd1 << head_addr : 32'd0) | (byp ? 32'd1 << i_mdu_addr : 32'd0);
  end
  // queue storage needs no reset; pointers decide what is valid
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_addr[wr_ptr[AW-1:0]] <= i_mdu_addr;
      q_data[wr_ptr[AW-1:0]] <= i_mdu_data;
    end
  end
  // pointers, scoreboard (set beats clear) and starvation tracking
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_busy      <= 32'd0;
      wait_cnt    <= 4'd0;
      o_stall_req <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_busy <= ((o_busy & ~clr_mask) | set_mask) & ~32'd1;
      if (pop) begin
        wait_cnt    <= 4'd0;
        o_stall_req <= 1'b0;
      end else if (!empty && i_wb_wren) begin
        wait_cnt <= wait_inc;
        if (wait_inc >= MW) o_stall_req <= 1'b1;
      end
    end
  end
endmodule
